// File: rtl/irq_sequencer.sv
// irq_sequencer: reset/NMI/IRQ/BRK entry sequencer. It pushes PC and status, fetches the vector, then loads PC and sets I.
// Optional NMI_HIJACK_EN: an NMI pending at PST redirects an IRQ/BRK sequence to the NMI vector.
module irq_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-REG_WIDTH-1:0] STACK_PAGE = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boundary,
  input  logic                  irq_n,
  input  logic                  nmi_n,
  input  logic                  brk_req,
  input  logic                  i_flag,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  sp_in,
  input  logic [REG_WIDTH-1:0]  status_in,
  input  logic [REG_WIDTH-1:0]  bus_din,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [REG_WIDTH-1:0]  bus_dout,
  output logic                  bus_rw_n,
  output logic [REG_WIDTH-1:0]  sp_out,
  output logic                  sp_we,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_we,
  output logic                  set_i,
  output logic [1:0]            vec_kind,
  output logic                  done
);
  typedef enum logic [3:0] {IDLE, D1, D2, PCH, PCL, PST, VLO, VHI, LOAD} state_t;

  localparam logic [1:0] K_RST = 2'b01, K_NMI = 2'b10, K_IRQ = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] VEC_NMI = ~ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] VEC_RST = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] VEC_IRQ = ~ADDR_WIDTH'(1);

  state_t                state;
  logic                  rst_pending, nmi_pending, nmi_prev;
  logic [1:0]            kind_r;
  logic                  brk_r;
  logic [REG_WIDTH-1:0]  sp_r, vec_lo, push_data;
  logic [ADDR_WIDTH-1:0] pc_r, vec_base;
  logic                  start, start_brk, hijack, nmi_fall, nmi_clr, is_rst;
  logic [1:0]            start_kind;

  assign nmi_fall = nmi_prev & ~nmi_n;
  assign is_rst   = (kind_r == K_RST);

`ifdef NMI_HIJACK_EN
  assign hijack = (state == PST) && (kind_r == K_IRQ) && nmi_pending;
`else
  assign hijack = 1'b0;
`endif

  assign nmi_clr = ((state == IDLE) && start && (start_kind == K_NMI)) || hijack;

  // Priority: reset > NMI > BRK > unmasked IRQ; only reset ignores boundary.
  always_comb begin
    start      = 1'b0;
    start_kind = 2'b00;
    start_brk  = 1'b0;
    if (rst_pending) begin
      start      = 1'b1;
      start_kind = K_RST;
    end else if (boundary) begin
      if (nmi_pending) begin
        start      = 1'b1;
        start_kind = K_NMI;
      end else if (brk_req) begin
        start      = 1'b1;
        start_kind = K_IRQ;
        start_brk  = 1'b1;
      end else if (!irq_n && !i_flag) begin
        start      = 1'b1;
        start_kind = K_IRQ;
      end
    end
  end

  // Data for the push cycle being entered: D2->PCH, PCH->PCL, PCL->PST.
  always_comb begin
    push_data = '0;
    case (state)
      D2:  push_data = pc_r[ADDR_WIDTH-1 -: REG_WIDTH];
      PCH: push_data = pc_r[REG_WIDTH-1:0];
      PCL: begin
        push_data    = status_in;
        push_data[5] = 1'b1;
        push_data[4] = brk_r;
      end
      default: push_data = '0;
    endcase
  end

  always_comb begin
    case (hijack ? K_NMI : kind_r)
      K_NMI:   vec_base = VEC_NMI;
      K_RST:   vec_base = VEC_RST;
      default: vec_base = VEC_IRQ;
    endcase
  end

  // Outputs are registered for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rst_pending <= 1'b1;
      nmi_pending <= 1'b0;
      nmi_prev    <= 1'b1;
      kind_r      <= 2'b00;
      brk_r       <= 1'b0;
      sp_r        <= '0;
      pc_r        <= '0;
      vec_lo      <= '0;
      busy        <= 1'b0;
      bus_addr    <= '0;
      bus_dout    <= '0;
      bus_rw_n    <= 1'b1;
      sp_out      <= '0;
      sp_we       <= 1'b0;
      pc_out      <= '0;
      pc_we       <= 1'b0;
      set_i       <= 1'b0;
      vec_kind    <= 2'b00;
      done        <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      if (nmi_fall)     nmi_pending <= 1'b1;
      else if (nmi_clr) nmi_pending <= 1'b0;
      sp_we <= 1'b0;
      pc_we <= 1'b0;
      set_i <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= D1;
          busy     <= 1'b1;
          bus_addr <= pc_in;
          bus_rw_n <= 1'b1;
          pc_r     <= pc_in;
          sp_r     <= sp_in;
          kind_r   <= start_kind;
          brk_r    <= start_brk;
          vec_kind <= start_kind;
          if (start_kind == K_RST) rst_pending <= 1'b0;
        end
        D1: state <= D2;
        D2, PCH, PCL: begin
          state    <= (state == D2) ? PCH : (state == PCH) ? PCL : PST;
          bus_addr <= {STACK_PAGE, sp_r};
          bus_dout <= is_rst ? '0 : push_data;
          bus_rw_n <= is_rst;
          sp_out   <= sp_r - 1'b1;
          sp_we    <= 1'b1;
          sp_r     <= sp_r - 1'b1;
        end
        PST: begin
          state    <= VLO;
          bus_addr <= vec_base;
          bus_dout <= '0;
          bus_rw_n <= 1'b1;
          if (hijack) begin
            kind_r   <= K_NMI;
            vec_kind <= K_NMI;
          end
        end
        VLO: begin
          state    <= VHI;
          vec_lo   <= bus_din;
          bus_addr <= bus_addr + 1'b1;
        end
        VHI: begin
          state    <= LOAD;
          bus_addr <= '0;
          pc_out   <= {bus_din, vec_lo};
          pc_we    <= 1'b1;
          set_i    <= 1'b1;
          done     <= 1'b1;
        end
        LOAD: begin
          state    <= IDLE;
          busy     <= 1'b0;
          vec_kind <= 2'b00;
          pc_out   <= '0;
          sp_out   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: a memory model serves vectors and records stack pushes.
module tb_irq_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        boundary = 1'b0, irq_n = 1'b1, nmi_n = 1'b1, brk_req = 1'b0, i_flag = 1'b1;
  logic [15:0] pc_in = 16'h8000;
  logic [7:0]  sp_in = 8'hFD, status_in = 8'h00, bus_din;
  logic        busy, bus_rw_n, sp_we, pc_we, set_i, done;
  logic [15:0] bus_addr, pc_out;
  logic [7:0]  bus_dout, sp_out;
  logic [1:0]  vec_kind;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0, n_fail = 0;

  logic [15:0] a [1:8];
  logic [15:0] pco [1:8];
  logic [7:0]  d [1:8];
  logic [7:0]  spo [1:8];
  logic [1:0]  vk [1:8];
  logic        rw [1:8];
  logic        pcwe [1:8];
  logic        seti [1:8];
  logic        dn [1:8];
  logic        bz [1:8];
  logic        seen;

  irq_sequencer dut (
    .clk(clk), .reset(reset), .boundary(boundary), .irq_n(irq_n), .nmi_n(nmi_n),
    .brk_req(brk_req), .i_flag(i_flag), .pc_in(pc_in), .sp_in(sp_in),
    .status_in(status_in), .bus_din(bus_din), .busy(busy), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_rw_n(bus_rw_n), .sp_out(sp_out), .sp_we(sp_we),
    .pc_out(pc_out), .pc_we(pc_we), .set_i(set_i), .vec_kind(vec_kind), .done(done)
  );

  always #5 clk = ~clk;
  assign bus_din = mem[bus_addr];
  always @(posedge clk) if (busy && !bus_rw_n) mem[bus_addr] <= bus_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Samples the 8 cycles after the start edge; optionally drops nmi_n at one of them.
  task automatic run_seq(input int fall_at);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a[i] = bus_addr; d[i] = bus_dout; rw[i] = bus_rw_n; spo[i] = sp_out;
      vk[i] = vec_kind; pcwe[i] = pc_we; pco[i] = pc_out; seti[i] = set_i;
      dn[i] = done; bz[i] = busy;
      if (i == fall_at) nmi_n = 1'b0;
    end
  endtask

  task automatic check_seq(input string tag, input logic [1:0] k1, input logic [1:0] k8,
                           input logic [7:0] sp, input logic [15:0] base,
                           input logic [15:0] pc_exp, input logic [7:0] st_exp, input logic wr);
    logic [7:0] sp1, sp2, sp3;
    sp1 = sp - 8'd1; sp2 = sp - 8'd2; sp3 = sp - 8'd3;
    chk({tag, ".busy"}, bz[1], 1'b1);
    chk({tag, ".kind_d1"}, vk[1], k1);
    chk({tag, ".kind_load"}, vk[8], k8);
    chk({tag, ".d1_addr"}, a[1], pc_in);
    chk({tag, ".push_addr"}, {a[3], a[4], a[5]}, {8'h01, sp, 8'h01, sp1, 8'h01, sp2});
    chk({tag, ".push_rw"}, {rw[3], rw[4], rw[5]}, wr ? 3'b000 : 3'b111);
    if (wr) chk({tag, ".push_data"}, {d[3], d[4], d[5]}, {pc_in, st_exp});
    else    chk({tag, ".push_data"}, {d[3], d[4], d[5]}, 24'h0);
    chk({tag, ".sp_out"}, spo[5], sp3);
    chk({tag, ".vec_addr"}, {a[6], a[7]}, {base, base + 16'd1});
    chk({tag, ".early_pcwe"}, pcwe[7], 1'b0);
    chk({tag, ".load"}, {pcwe[8], seti[8], dn[8], pco[8]}, {3'b111, pc_exp});
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, ".idle"}, {busy, vec_kind, pc_we}, 4'b0000);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hA0;

    // Reset state and power-on sequence
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, bus_rw_n, bus_addr, sp_we, pc_we, set_i, vec_kind, done},
        {1'b0, 1'b1, 16'h0, 3'b000, 2'b00, 1'b0});
    reset = 1'b0;
    run_seq(0);
    check_seq("rst", 2'b01, 2'b01, 8'hFD, 16'hFFFC, 16'h1234, 8'h00, 1'b0);
    idle_check("rst");

    // Masked IRQ stays idle, then unmasked IRQ runs
    boundary = 1'b1; irq_n = 1'b0; i_flag = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen |= busy; end
    chk("masked_irq", seen, 1'b0);
    i_flag = 1'b0;
    run_seq(0);
    irq_n = 1'b1; i_flag = 1'b1;
    check_seq("irq", 2'b11, 2'b11, 8'hFD, 16'hFFFE, 16'hA000, 8'h20, 1'b1);
    chk("irq_mem_status", mem[16'h01FB], 8'h20);
    idle_check("irq");

    // NMI held low gives exactly one sequence
    nmi_n = 1'b0;
    @(negedge clk);
    run_seq(0);
    check_seq("nmi", 2'b10, 2'b10, 8'hFD, 16'hFFFA, 16'h9000, 8'h20, 1'b1);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); seen |= busy; end
    chk("nmi_single", seen, 1'b0);
    nmi_n = 1'b1;
    @(negedge clk);

    // Second NMI edge while busy queues a follow-on sequence
    nmi_n = 1'b0;
    @(negedge clk);
    nmi_n = 1'b1;
    run_seq(3);
    check_seq("nmi2a", 2'b10, 2'b10, 8'hFD, 16'hFFFA, 16'h9000, 8'h20, 1'b1);
    idle_check("nmi2a");
    run_seq(0);
    check_seq("nmi2b", 2'b10, 2'b10, 8'hFD, 16'hFFFA, 16'h9000, 8'h20, 1'b1);
    idle_check("nmi2b");
    nmi_n = 1'b1;

    // BRK pushes B flag
    brk_req = 1'b1; status_in = 8'h00;
    run_seq(0);
    brk_req = 1'b0;
    check_seq("brk", 2'b11, 2'b11, 8'hFD, 16'hFFFE, 16'hA000, 8'h30, 1'b1);
    idle_check("brk");

    // Stack pointer wraps inside page 1
    sp_in = 8'h01; irq_n = 1'b0; i_flag = 1'b0;
    run_seq(0);
    irq_n = 1'b1;
    check_seq("spwrap", 2'b11, 2'b11, 8'h01, 16'hFFFE, 16'hA000, 8'h20, 1'b1);
    chk("spwrap_last", {a[5], spo[5]}, {16'h01FF, 8'hFE});
    idle_check("spwrap");

    // NMI edge during PCL of an IRQ
    sp_in = 8'hFD; irq_n = 1'b0;
    run_seq(4);
    irq_n = 1'b1;
`ifdef NMI_HIJACK_EN
    check_seq("hijack", 2'b11, 2'b10, 8'hFD, 16'hFFFA, 16'h9000, 8'h20, 1'b1);
    chk("hijack_kind_pst", vk[5], 2'b11);
    seen = 1'b0;
    repeat (6) begin @(negedge clk); seen |= busy; end
    chk("hijack_single", seen, 1'b0);
`else
    check_seq("nohijack_irq", 2'b11, 2'b11, 8'hFD, 16'hFFFE, 16'hA000, 8'h20, 1'b1);
    idle_check("nohijack_irq");
    run_seq(0);
    check_seq("nohijack_nmi", 2'b10, 2'b10, 8'hFD, 16'hFFFA, 16'h9000, 8'h20, 1'b1);
    idle_check("nohijack_nmi");
`endif
    nmi_n = 1'b1;
    @(negedge clk);

    // Reset during PCL abandons the IRQ; a full reset sequence follows
    mem[16'h01FC] = 8'hEE; mem[16'h01FB] = 8'hEE;
    irq_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_pcl", {busy, bus_rw_n, bus_addr}, {2'b10, 16'h01FC});
    reset = 1'b1;
    #1;
    chk("reset_mid", {busy, bus_rw_n, bus_addr, sp_we, pc_we, vec_kind}, {2'b01, 16'h0, 2'b00, 2'b00});
    irq_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_no_write", {mem[16'h01FC], mem[16'h01FB]}, 16'hEEEE);
    reset = 1'b0;
    run_seq(0);
    check_seq("rst2", 2'b01, 2'b01, 8'hFD, 16'hFFFC, 16'h1234, 8'h00, 1'b0);
    idle_check("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Controller that takes over the CPU datapath at an instruction boundary for the reset, NMI, IRQ and BRK sequences.
- Per sequence: pushes PC and status to the stack page, fetches the 16-bit vector, loads PC and sets the I flag.
- Sits beside the decoder; while busy=1 the top level switches the address/data bus and the PC/SP write enables to this block.

Parameters:
ADDR_WIDTH, 16, address bus width
REG_WIDTH, 8, data/register width
STACK_PAGE, 8'h01, high address byte for stack accesses

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous reset, active-high
boundary  input  1  decoder is at an instruction boundary; a sequence may start
irq_n  input  1  level-sensitive interrupt request, active-low
nmi_n  input  1  non-maskable interrupt, falling-edge triggered
brk_req  input  1  decoder decoded BRK (sampled with boundary)
i_flag  input  1  current interrupt-disable flag
pc_in  input  ADDR_WIDTH  current PC
sp_in  input  REG_WIDTH  current stack pointer
status_in  input  REG_WIDTH  current status register
bus_din  input  REG_WIDTH  read data from memory
busy  output  1  sequencer owns the bus
bus_addr  output  ADDR_WIDTH  memory address
bus_dout  output  REG_WIDTH  write data
bus_rw_n  output  1  1=read, 0=write
sp_out  output  REG_WIDTH  new stack pointer
sp_we  output  1  write strobe for sp_out
pc_out  output  ADDR_WIDTH  new PC (vector)
pc_we  output  1  write strobe for pc_out
set_i  output  1  one-cycle pulse: set I flag
vec_kind  output  2  00 none, 01 reset, 10 NMI, 11 IRQ/BRK
done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Async reset:
  - State=IDLE; all outputs 0 except bus_rw_n=1.
  - rst_pending=1, nmi_pending=0, nmi_prev=1.
  - Applies mid-sequence too: the sequence is abandoned and nothing further is written.
- NMI detect: nmi_prev<=nmi_n every clk. nmi_prev=1 && nmi_n=0 sets nmi_pending. A set and a clear in the same cycle leave nmi_pending=1.
- Start, evaluated in IDLE only. Priority is reset > NMI > BRK > IRQ:
  - rst_pending: starts unconditionally, without boundary.
  - Otherwise requires boundary=1, then nmi_pending, else brk_req, else irq_n=0 && i_flag=0.
  - Masked IRQ: no start.
- On start: capture kind, sp_in and pc_in into internal regs; go to D1. NMI start clears nmi_pending; reset start clears rst_pending.
- States, one clk each: IDLE, D1, D2, PCH, PCL, PST, VLO, VHI, LOAD. busy=1 in D1..LOAD.
  - D1, D2: read at pc.
  - PCH, PCL, PST: addr={STACK_PAGE,sp}; sp_out=sp-1 (mod 256); sp_we=1; internal sp decrements.
    - Data in order: pc[15:8], pc[7:0], then status with bit5=1 and bit4=1 for BRK, 0 otherwise.
    - bus_rw_n=0 except for the reset kind, which reads (bus_rw_n=1, bus_dout=0) but still decrements SP by 3.
  - VLO: read at vector base, latch bus_din as low byte. Vector base: NMI FFFA, reset FFFC, IRQ/BRK FFFE.
  - VHI: read at base+1, latch high byte.
  - LOAD: pc_out={hi,lo}, pc_we=1, set_i=1, done=1, busy=1 for this last cycle; then IDLE.
- Latency: start cycle to pc_we = 9 clks.
- SP wraps within the stack page: 0x00 -> 0xFF, addr 0x01FF.
- vec_kind valid from D1 through LOAD; 0 in IDLE.
- brk_req and irq_n are ignored while busy. irq_n must still be low when sampled in IDLE.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined: if nmi_pending=1 at the PST cycle of an IRQ/BRK sequence, VLO/VHI use FFFA/FFFB, vec_kind becomes 10 from VLO onward, and nmi_pending clears. The already-pushed B bit is unchanged.
- Undefined: the NMI stays pending and starts its own sequence at the next boundary after LOAD.

Test Plan:
- Reset release, sp_in=FD, mem[FFFC]=34, mem[FFFD]=12 -> three reads at 01FD/01FC/01FB, sp_out=FA, pc_out=1234 with pc_we at clk 9, no writes, vec_kind=01.
- i_flag=1, irq_n=0, boundary=1 -> busy stays 0. Then i_flag=0 -> writes PCH/PCL/status (bit4=0, bit5=1), vector read at FFFE/FFFF, set_i pulse.
- Single nmi_n falling edge held low 20 clks -> exactly one NMI sequence via FFFA. A second edge during busy -> a second sequence after done.
- brk_req=1 with status_in=00 -> pushed status=30, vector FFFE, vec_kind=11.
- sp_in=01 during IRQ -> pushes at 0101, 0100, 01FF; final sp_out=FE.
- With NMI_HIJACK_EN, NMI edge during PCL of an IRQ -> vector FFFA, single sequence, nmi_pending=0 after. Without the macro -> IRQ vector, then an NMI sequence follows.
- Assert reset during PCL of an IRQ -> outputs zero immediately; after release a full reset sequence runs.
